mem_block_copier: RTL and testbench

Memory-side initiator for the byte-addressed single-port data memory. It drives that memory's WE/ADDR/WD/RD port and copies LEN words from SRC to DST, one word per read-then-write pair. The block sits beside the datapath as a block-move engine. It is muxed onto the memory port whenever BUSY is high.

---
 rtl/mem_block_copier.sv | 137 +++++++++++++
 tb/tb_mem_block_copier.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_copier.sv
// Block-move engine: copies LEN words from SRC to DST through a single-port byte-addressed memory.
// Optional MEM_COPY_FILL_EN adds FILL/PATTERN ports for a one-cycle-per-word pattern fill.
module mem_block_copier #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    START,
  input  logic [ADDR_WIDTH-1:0]   SRC,
  input  logic [ADDR_WIDTH-1:0]   DST,
  input  logic [LEN_WIDTH-1:0]    LEN,
`ifdef MEM_COPY_FILL_EN
  input  logic                    FILL,
  input  logic [BYTE_SIZE*8-1:0]  PATTERN,
`endif
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    MEM_WE,
  output logic [ADDR_WIDTH-1:0]   MEM_ADDR,
  output logic [BYTE_SIZE*8-1:0]  MEM_WD,
  input  logic [BYTE_SIZE*8-1:0]  MEM_RD
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_WIDTH-1:0]  STRIDE     = ADDR_WIDTH'(BYTE_SIZE);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]   CNT_ZERO   = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]   CNT_ONE    = LEN_WIDTH'(1);
  localparam logic [BYTE_SIZE*8-1:0] DATA_ZERO  = {(BYTE_SIZE*8){1'b0}};

  logic [1:0]             state_r;
  logic [ADDR_WIDTH-1:0]  src_ptr_r;
  logic [ADDR_WIDTH-1:0]  dst_ptr_r;
  logic [LEN_WIDTH-1:0]   count_r;
  logic [BYTE_SIZE*8-1:0] data_r;
  logic                   fill_r;
  logic                   fill_in_s;
  logic [BYTE_SIZE*8-1:0] pattern_in_s;

  // Without the fill option the fill path is tied off and optimises away.
`ifdef MEM_COPY_FILL_EN
  assign fill_in_s    = FILL;
  assign pattern_in_s = PATTERN;
`else
  assign fill_in_s    = 1'b0;
  assign pattern_in_s = DATA_ZERO;
`endif

  // Sequencer state, pointers, word count and the staged data word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      src_ptr_r <= ADDR_ZERO;
      dst_ptr_r <= ADDR_ZERO;
      count_r   <= CNT_ZERO;
      data_r    <= DATA_ZERO;
      fill_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (START) begin
            src_ptr_r <= SRC;
            dst_ptr_r <= DST;
            count_r   <= LEN;
            fill_r    <= fill_in_s;
            if (LEN == CNT_ZERO) begin
              state_r <= S_FIN;
            end else if (fill_in_s) begin
              data_r  <= pattern_in_s;
              state_r <= S_WRITE;
            end else begin
              state_r <= S_READ;
            end
          end
        end
        S_READ: begin
          data_r    <= MEM_RD;
          src_ptr_r <= src_ptr_r + STRIDE;
          state_r   <= S_WRITE;
        end
        S_WRITE: begin
          dst_ptr_r <= dst_ptr_r + STRIDE;
          count_r   <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= S_FIN;
          end else if (fill_r) begin
            state_r <= S_WRITE;
          end else begin
            state_r <= S_READ;
          end
        end
        S_FIN: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Memory port and status decode; reset forces IDLE so MEM_WE drops at once.
  always_comb begin
    BUSY     = 1'b0;
    DONE     = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = ADDR_ZERO;
    MEM_WD   = data_r;
    case (state_r)
      S_IDLE: begin
        MEM_WD = DATA_ZERO;
      end
      S_READ: begin
        BUSY     = 1'b1;
        MEM_ADDR = src_ptr_r;
      end
      S_WRITE: begin
        BUSY     = 1'b1;
        MEM_WE   = 1'b1;
        MEM_ADDR = dst_ptr_r;
      end
      S_FIN: begin
        DONE = 1'b1;
      end
      default: begin
        MEM_WD = DATA_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Self-checking bench for mem_block_copier with a 256-byte little-endian memory model.
module tb_mem_block_copier;

  logic        clk;
  logic        reset;
  logic        START;
  logic [31:0] SRC;
  logic [31:0] DST;
  logic [7:0]  LEN;
`ifdef MEM_COPY_FILL_EN
  logic        FILL;
  logic [31:0] PATTERN;
`endif
  logic        BUSY;
  logic        DONE;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  mem_block_copier #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .START(START), .SRC(SRC), .DST(DST), .LEN(LEN),
`ifdef MEM_COPY_FILL_EN
    .FILL(FILL), .PATTERN(PATTERN),
`endif
    .BUSY(BUSY), .DONE(DONE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  logic       pre_req;
  logic [1:0] pre_mode;
  assign a0 = MEM_ADDR[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign MEM_RD = {mem[a3], mem[a2], mem[a1], mem[a0]};

  // Memory model: preload on request, otherwise commit writes on the edge.
  always @(posedge clk) begin
    if (pre_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      if (pre_mode == 2'd0) begin
        for (int i = 0; i < 8; i++) mem[i] <= 8'(i + 1);
      end else begin
        mem[0] <= 8'hAA; mem[1] <= 8'hBB; mem[2] <= 8'hCC; mem[3] <= 8'hDD;
      end
    end else if (MEM_WE) begin
      mem[a0] <= MEM_WD[7:0];
      mem[a1] <= MEM_WD[15:8];
      mem[a2] <= MEM_WD[23:16];
      mem[a3] <= MEM_WD[31:24];
    end
  end

  int checks;
  int failures;

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [1:0] mode);
    @(negedge clk);
    pre_mode = mode;
    pre_req  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  // Returns at the sample point of the cycle after the accepting edge.
  task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l,
                           input logic f);
    @(negedge clk);
    SRC = s; DST = d; LEN = l; START = 1'b1;
`ifdef MEM_COPY_FILL_EN
    FILL = f; PATTERN = 32'h5A5A5A5A;
`else
    if (f) $display("fill requested without fill build");
`endif
    @(posedge clk);
    @(negedge clk);
    START = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  pre;
    logic [31:0] src, dst;
    logic [7:0]  len;
    logic [31:0] lat, busy, we;
    logic [31:0] ca1, cw1, ca2, cw2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n, nb, nw, fw, lw, nd;
    checks = 0; failures = 0;
    reset = 1'b1; START = 1'b0; SRC = 32'd0; DST = 32'd0; LEN = 8'd0;
    pre_req = 1'b0; pre_mode = 2'd0;
`ifdef MEM_COPY_FILL_EN
    FILL = 1'b0; PATTERN = 32'd0;
`endif
    vecs[0] = '{2'd0, 32'd0, 32'd8, 8'd2, 32'd4, 32'd4, 32'd2, 32'd8, 32'h04030201, 32'd12, 32'h08070605};
    vecs[1] = '{2'd0, 32'd0, 32'd8, 8'd0, 32'd0, 32'd0, 32'd0, 32'd8, 32'h00000000, 32'd0, 32'h04030201};
    vecs[2] = '{2'd1, 32'd0, 32'd4, 8'd2, 32'd4, 32'd4, 32'd2, 32'd4, 32'hDDCCBBAA, 32'd8, 32'hDDCCBBAA};
    vecs[3] = '{2'd0, 32'd1, 32'd20, 8'd1, 32'd2, 32'd2, 32'd1, 32'd20, 32'h05040302, 32'd24, 32'h00000000};
    vecs[4] = '{2'd0, 32'd4, 32'd32, 8'd1, 32'd2, 32'd2, 32'd1, 32'd32, 32'h08070605, 32'd36, 32'h00000000};
    vecs[5] = '{2'd0, 32'hFFFFFFFC, 32'd16, 8'd2, 32'd4, 32'd4, 32'd2, 32'd16, 32'h00000000, 32'd20, 32'h04030201};
    vecs[6] = '{2'd0, 32'd0, 32'd0, 8'd255, 32'd510, 32'd510, 32'd255, 32'd0, 32'h04030201, 32'd4, 32'h08070605};

    #12;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_we", {31'd0, MEM_WE}, 32'd0);
    check("rst_addr", MEM_ADDR, 32'd0);
    check("rst_wd", MEM_WD, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      preload(vecs[v].pre);
      start_job(vecs[v].src, vecs[v].dst, vecs[v].len, 1'b0);
      n = 0; nb = 0; nw = 0;
      while (!DONE && n < 1000) begin
        if (BUSY) nb++;
        if (MEM_WE) nw++;
        @(negedge clk);
        n++;
      end
      check($sformatf("v%0d_latency", v), 32'(n), vecs[v].lat);
      check($sformatf("v%0d_busy", v), 32'(nb), vecs[v].busy);
      check($sformatf("v%0d_we", v), 32'(nw), vecs[v].we);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), {30'd0, DONE, BUSY}, 32'd0);
      check($sformatf("v%0d_mem1", v), word_at(vecs[v].ca1[7:0]), vecs[v].cw1);
      check($sformatf("v%0d_mem2", v), word_at(vecs[v].ca2[7:0]), vecs[v].cw2);
    end

    // START during an active copy has no effect.
    preload(2'd0);
    start_job(32'd0, 32'd32, 8'd3, 1'b0);
    nw = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin START = 1'b1; SRC = 32'd4; DST = 32'd64; end
      if (i == 3) START = 1'b0;
      if (MEM_WE) nw++;
      if (DONE) nd++;
      @(negedge clk);
    end
    check("busy_start_we", 32'(nw), 32'd3);
    check("busy_start_done", 32'(nd), 32'd1);
    check("busy_start_w36", word_at(8'd36), 32'h08070605);
    check("busy_start_w40", word_at(8'd40), 32'h00000000);
    check("busy_start_w64", word_at(8'd64), 32'h00000000);

    // Reset asserted during the second WRITE of a 3-word copy.
    preload(2'd0);
    start_job(32'd0, 32'd32, 8'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rw_pre_we", {31'd0, MEM_WE}, 32'd1);
    reset = 1'b1;
    #1;
    check("rw_we", {31'd0, MEM_WE}, 32'd0);
    check("rw_outs", {29'd0, BUSY, DONE, MEM_WE}, 32'd0);
    check("rw_addr", MEM_ADDR, 32'd0);
    check("rw_wd", MEM_WD, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rw_w32", word_at(8'd32), 32'h04030201);
    check("rw_w36", word_at(8'd36), 32'h00000000);
    start_job(32'd4, 32'd48, 8'd1, 1'b0);
    n = 0;
    while (!DONE && n < 20) begin @(negedge clk); n++; end
    check("rw_restart_lat", 32'(n), 32'd2);
    check("rw_restart_w48", word_at(8'd48), 32'h08070605);

`ifdef MEM_COPY_FILL_EN
    preload(2'd0);
    start_job(32'd0, 32'd0, 8'd4, 1'b1);
    n = 0; nw = 0; fw = -1; lw = -1;
    while (!DONE && n < 50) begin
      if (MEM_WE) begin nw++; if (fw < 0) fw = n; lw = n; end
      @(negedge clk);
      n++;
    end
    check("fill_lat", 32'(n), 32'd4);
    check("fill_we", 32'(nw), 32'd4);
    check("fill_consec", 32'(lw - fw), 32'd3);
    check("fill_w0", word_at(8'd0), 32'h5A5A5A5A);
    check("fill_w12", word_at(8'd12), 32'h5A5A5A5A);
    check("fill_w16", word_at(8'd16), 32'h00000000);
    FILL = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
